// File: rtl/machine_timer.sv
// machine_timer
//   RISC-V machine timer: a free-running 64-bit mtime, a 64-bit mtimecmp and a
//   level interrupt. Software reaches it as a Wishbone B4 pipelined slave.
//   Reading MTIME_LO captures mtime[63:32] into a shadow register, and a later
//   MTIME_HI read returns that shadow. Software therefore gets a tear-free
//   64-bit value by reading LO first and then HI.
//
//   Register map (wb_adr_i[4:2]):
//     0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL,
//     5..7 unmapped (read 0, writes ignored, still acked)
//   CTRL bit 0 = EN (reset 1). This bit enables counting.
//
//   Optional feature macro: MTIMER_PRESCALER_EN
//     When defined, CTRL[16+PRESC_W-1:16] holds PRESC. mtime then advances once
//     every PRESC+1 enabled cycles. PRESC_W must not exceed 16.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   wb_cyc_i     bus cycle
//   wb_stb_i     strobe
//   wb_we_i      write enable
//   wb_adr_i     byte address, [4:2] selects the register
//   wb_sel_i     byte lanes
//   wb_dat_i     write data
//   wb_dat_o     read data, valid with wb_ack_o
//   wb_ack_o     acknowledge, one cycle after the request
//   wb_stall_o   always 0
//   irq_timer_o  machine timer interrupt, level, registered
module machine_timer #(
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          PRESC_W      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        irq_timer_o
);
    localparam logic [2:0] ADR_MTIME_LO = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI = 3'd1;
    localparam logic [2:0] ADR_CMP_LO   = 3'd2;
    localparam logic [2:0] ADR_CMP_HI   = 3'd3;
    localparam logic [2:0] ADR_CTRL     = 3'd4;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [31:0] r_shadowHi;
    logic        r_ack;
    logic [31:0] r_datO;
    logic        r_irq;

    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_idx;
    logic        w_mtimeLoWr;
    logic        w_mtimeHiWr;
    logic        w_ctrlWrEn;
    logic        w_tick;
    logic [31:0] w_ctrlRd;
    logic [31:0] w_ctrlWr;
    logic [31:0] w_rdData;
    logic        w_unused;

    // Replace only the byte lanes selected by sel. All other bytes keep the old value.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

    assign w_req       = wb_cyc_i & wb_stb_i;
    assign w_wr        = w_req & wb_we_i;
    assign w_rd        = w_req & ~wb_we_i;
    assign w_idx       = wb_adr_i[4:2];
    // A write with no byte lanes changes nothing, so the tick still happens.
    assign w_mtimeLoWr = w_wr && (w_idx == ADR_MTIME_LO) && (|wb_sel_i);
    assign w_mtimeHiWr = w_wr && (w_idx == ADR_MTIME_HI) && (|wb_sel_i);
    assign w_ctrlWrEn  = w_wr && (w_idx == ADR_CTRL);
    assign w_ctrlWr    = mergeBytes(w_ctrlRd, wb_dat_i, wb_sel_i);

`ifdef MTIMER_PRESCALER_EN
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_div;

    assign w_ctrlRd = (32'(r_presc) << 16) | {31'd0, r_en};
    assign w_tick   = r_en && (r_div == r_presc);

    // Prescaler: the divider counts 0..PRESC. Any CTRL write restarts it, so a
    // new PRESC takes effect from a clean phase. EN=0 holds the divider.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
            r_div   <= '0;
        end else begin
            if (w_ctrlWrEn) begin
                r_presc <= w_ctrlWr[16 +: PRESC_W];
                r_div   <= '0;
            end else if (r_en) begin
                r_div <= (r_div == r_presc) ? '0 : r_div + 1'b1;
            end
        end
    end
`else
    assign w_ctrlRd = {31'd0, r_en};
    assign w_tick   = r_en;
`endif

    assign w_unused = ^{wb_adr_i[1:0], w_ctrlWr};

    // mtime: a bus write has priority over the tick. The written half takes the
    // merged bytes and the other half keeps its pre-tick value, so software
    // never sees a lost or duplicated count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime <= 64'd0;
        end else if (w_mtimeLoWr) begin
            r_mtime[31:0] <= mergeBytes(r_mtime[31:0], wb_dat_i, wb_sel_i);
        end else if (w_mtimeHiWr) begin
            r_mtime[63:32] <= mergeBytes(r_mtime[63:32], wb_dat_i, wb_sel_i);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Snapshot of the high word. It is captured on an MTIME_LO read, so the
    // next MTIME_HI read matches that low word. A write to MTIME_HI also
    // updates the shadow, so the written value reads back directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadowHi <= 32'd0;
        end else if (w_mtimeHiWr) begin
            r_shadowHi <= mergeBytes(r_mtime[63:32], wb_dat_i, wb_sel_i);
        end else if (w_rd && (w_idx == ADR_MTIME_LO)) begin
            r_shadowHi <= r_mtime[63:32];
        end
    end

    // Compare value and enable bit. Both are plain byte-lane writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtimecmp <= MTIMECMP_RST;
            r_en       <= 1'b1;
        end else if (w_wr) begin
            if (w_idx == ADR_CMP_LO)
                r_mtimecmp[31:0] <= mergeBytes(r_mtimecmp[31:0], wb_dat_i, wb_sel_i);
            if (w_idx == ADR_CMP_HI)
                r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], wb_dat_i, wb_sel_i);
            if (w_idx == ADR_CTRL)
                r_en <= w_ctrlWr[0];
        end
    end

    // Read data mux. It is sampled into wb_dat_o together with the ack.
    always_comb begin
        w_rdData = 32'd0;
        case (w_idx)
            ADR_MTIME_LO: w_rdData = r_mtime[31:0];
            ADR_MTIME_HI: w_rdData = r_shadowHi;
            ADR_CMP_LO:   w_rdData = r_mtimecmp[31:0];
            ADR_CMP_HI:   w_rdData = r_mtimecmp[63:32];
            ADR_CTRL:     w_rdData = w_ctrlRd;
            default:      w_rdData = 32'd0;
        endcase
    end

    // Bus response: every accepted request gets exactly one ack, one cycle later.
    // The interrupt is the registered unsigned compare of the current mtime and mtimecmp.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_datO <= 32'd0;
            r_irq  <= 1'b0;
        end else begin
            r_ack  <= w_req;
            r_datO <= w_rd ? w_rdData : 32'd0;
            r_irq  <= (r_mtime >= r_mtimecmp);
        end
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_datO;
    assign wb_stall_o  = 1'b0;
    assign irq_timer_o = r_irq;
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer
//   Directed bench for machine_timer. Each bus request pushes its expected read
//   range into a queue. A monitor pops one entry per ack and compares the data
//   against it. The interrupt is checked at exact, hand-counted cycles.
module tb_machine_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [4:0]  adr = 5'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] datI = 32'd0;
    logic [31:0] datO;
    logic        ack;
    logic        stall;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          chk;
        logic [31:0] lo;
        logic [31:0] hi;
    } sbEntry_t;

    sbEntry_t sbq[$];

    localparam logic [4:0] A_MLO  = 5'h00;
    localparam logic [4:0] A_MHI  = 5'h04;
    localparam logic [4:0] A_CLO  = 5'h08;
    localparam logic [4:0] A_CHI  = 5'h0C;
    localparam logic [4:0] A_CTRL = 5'h10;
    localparam logic [4:0] A_UNM  = 5'h1C;

    machine_timer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_sel_i    (sel),
        .wb_dat_i    (datI),
        .wb_dat_o    (datO),
        .wb_ack_o    (ack),
        .wb_stall_o  (stall),
        .irq_timer_o (irq)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: one scoreboard entry per ack, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedAck: got ack with data %h, required no ack", datO);
            end else begin
                sbEntry_t e;
                e = sbq.pop_front();
                if (e.chk) begin
                    checks++;
                    if (datO < e.lo || datO > e.hi) begin
                        errors++;
                        $display("[TB] FAIL %s: got %h, required %h..%h", e.name, datO, e.lo, e.hi);
                    end
                end
            end
        end
    end

    // Issue one request, accepted on the next rising edge. Returns 1 ns after that edge.
    task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input bit chk,
                                 input logic [31:0] lo, input logic [31:0] hi,
                                 input string name);
        sbEntry_t e;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = wr;
        adr  = a;
        sel  = s;
        datI = d;
        e.name = name;
        e.chk  = chk;
        e.lo   = lo;
        e.hi   = hi;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        applyStimulus(1'b1, a, s, d, 1'b0, 32'd0, 32'd0, "write");
    endtask

    task automatic busRead(input logic [4:0] a, input string name,
                           input logic [31:0] lo, input logic [31:0] hi);
        applyStimulus(1'b0, a, 4'hF, 32'd0, 1'b1, lo, hi, name);
    endtask

    task automatic busIdle(input int n);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    initial begin
        int riseAt;
        $display("[TB] machine_timer bench start");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values. mtime counts from 0 after release, so it reads 23 at the 24th edge.
        busRead(A_MHI, "rstMtimeHi", 32'd0, 32'd0);
        busRead(A_CLO, "rstCmpLo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busRead(A_CHI, "rstCmpHi", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busIdle(20);
        busRead(A_MLO, "rstMtimeLo", 32'd22, 32'd24);
        busIdle(0);
        @(negedge clk);
        checkOutput("rstIrq", {31'd0, irq}, 32'd0);

        // Compare: mtime restarts at 0 and the irq rises one cycle after mtime==0x40.
        busWrite(A_CHI, 4'hF, 32'd0);
        busWrite(A_CLO, 4'hF, 32'h40);
        busWrite(A_MLO, 4'hF, 32'd0);
        busWrite(A_MHI, 4'hF, 32'd0);
        busIdle(0);
        riseAt = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (irq) begin
                riseAt = c;
                break;
            end
        end
        checkOutput("irqRiseCycle", 32'(riseAt), 32'd66);
        repeat (10) @(negedge clk);
        checkOutput("irqHold", {31'd0, irq}, 32'd1);
        busWrite(A_CHI, 4'hF, 32'd1);
        busIdle(0);
        @(negedge clk);
        checkOutput("irqFallNotYet", {31'd0, irq}, 32'd1);
        @(negedge clk);
        checkOutput("irqFall", {31'd0, irq}, 32'd0);

        // A write to MTIME_HI updates the shadow directly.
        busWrite(A_MHI, 4'hF, 32'h1234);
        busRead(A_MHI, "hiWriteShadow", 32'h1234, 32'h1234);

        // Snapshot across a wrap: LO is read at all-ones, and HI is read after mtime wrapped to 0.
        busWrite(A_MHI, 4'hF, 32'hFFFF_FFFF);
        busWrite(A_MLO, 4'hF, 32'hFFFF_FFFF);
        busRead(A_MLO, "snapLo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busRead(A_MHI, "snapHi", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Wrap: FFFF_FFFF_FFFF_FFF0 plus 0x20 ticks gives 0x10.
        busWrite(A_MHI, 4'hF, 32'hFFFF_FFFF);
        busWrite(A_MLO, 4'hF, 32'hFFFF_FFF0);
        busIdle(32);
        busRead(A_MLO, "wrapLo", 32'h10, 32'h10);
        busRead(A_MHI, "wrapHi", 32'd0, 32'd0);

        // Byte lanes, sel=0 and unmapped access
        busWrite(A_CLO, 4'hF, 32'hFFFF_FFFF);
        busWrite(A_CLO, 4'b0101, 32'hAABB_CCDD);
        busRead(A_CLO, "byteLanes", 32'hFFBB_FFDD, 32'hFFBB_FFDD);
        busWrite(A_CHI, 4'h0, 32'h5555_5555);
        busRead(A_CHI, "selZero", 32'd1, 32'd1);
        busWrite(A_UNM, 4'hF, 32'h1234_5678);
        busRead(A_UNM, "unmapped", 32'd0, 32'd0);

        // A write has priority over the tick: 0x100, 0x101, 0x102 with no loss or duplicate.
        busWrite(A_MLO, 4'hF, 32'h100);
        busRead(A_MLO, "wrTick0", 32'h100, 32'h100);
        busRead(A_MLO, "wrTick1", 32'h101, 32'h101);
        busRead(A_MLO, "wrTick2", 32'h102, 32'h102);

        // EN=0 freezes mtime. The tick in the CTRL write cycle still happens (0x201).
        busWrite(A_MLO, 4'hF, 32'h200);
        busWrite(A_CTRL, 4'hF, 32'd0);
        busRead(A_MLO, "frozen0", 32'h201, 32'h201);
        busIdle(5);
        busRead(A_MLO, "frozen1", 32'h201, 32'h201);
        busWrite(A_CTRL, 4'hF, 32'd1);

        // Prescaler setting (or its absence)
        busWrite(A_MLO, 4'hF, 32'd0);
        busWrite(A_CTRL, 4'hF, 32'h0003_0001);
        busIdle(100);
`ifdef MTIMER_PRESCALER_EN
        busRead(A_CTRL, "ctrlRead", 32'h0003_0001, 32'h0003_0001);
        busRead(A_MLO, "prescCount", 32'd25, 32'd27);
`else
        busRead(A_CTRL, "ctrlRead", 32'h1, 32'h1);
        busRead(A_MLO, "noPrescCount", 32'd100, 32'd104);
`endif
        busWrite(A_CTRL, 4'hF, 32'd1);

        // Reset in the middle of a transaction: the pending ack is dropped and the irq clears.
        busWrite(A_CLO, 4'hF, 32'd0);
        busWrite(A_CHI, 4'hF, 32'd0);
        busIdle(2);
        @(negedge clk);
        checkOutput("irqBeforeRst", {31'd0, irq}, 32'd1);
        applyStimulus(1'b0, A_MLO, 4'hF, 32'd0, 1'b0, 32'd0, 32'd0, "dropped");
        rst = 1'b1;
        busIdle(0);
        sbq.delete();
        @(negedge clk);
        checkOutput("rstAckDropped", {31'd0, ack}, 32'd0);
        checkOutput("rstIrqCleared", {31'd0, irq}, 32'd0);
        checkOutput("rstDatO", datO, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busRead(A_CLO, "postRstCmpLo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busRead(A_CTRL, "postRstCtrl", 32'h1, 32'h1);
        busRead(A_MHI, "postRstShadow", 32'd0, 32'd0);
        busIdle(0);

        // Drain the scoreboard within a bounded wait
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        checkOutput("sbDrain", 32'(sbq.size()), 32'd0);
        checkOutput("stallLow", {31'd0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
